// File: rtl/secure_pkg.sv
// rtl/secure_pkg.sv - shared FSM state type and default widths for the secure access path
package secure_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_KEY_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with priority mask and last-grant register
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request bits, one per requester
//   mask        requesters to demote (served only when no unmasked request is pending)
//   advance     grant is being consumed this cycle; updates the last-grant register
//   gnt_valid   some requester can be granted
//   gnt_idx     index of the chosen requester
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic       last_gnt;
    logic [1:0] open_req;
    logic [1:0] cand;

    // Masked (locked) requesters still get served, but only when nobody
    // unmasked is asking; they receive an error response upstream.
    assign open_req  = req & ~mask;
    assign cand      = (open_req != 2'b00) ? open_req : req;
    assign gnt_valid = |cand;

    always_comb begin
        gnt_idx = 1'b0;
        case (cand)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_gnt;
            default: gnt_idx = 1'b0;
        endcase
    end

    // Starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (advance && gnt_valid) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/secure_access_ctrl.sv
// rtl/secure_access_ctrl.sv - arbitrated, key-checked access sequencer with per-requester lockout
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]       request handshake, bit i = requester i (0 host, 1 DMA)
//   req_we/req_enc [1:0]            write select, encrypted-output select
//   req_addr/req_wdata/req_key      packed per requester, requester i at [i*W +: W]
//   rsp_valid [1:0], rsp_err        response pulse, error qualifier (key mismatch or locked)
//   rsp_data                        read data, zero on writes and errors
//   mem_address, mem_write,
//   read_enable, mem_write_data,
//   encryption_on                   memory/security datapath controls
//   mem_key, mem_read_data          key_access word, read data (one cycle after read_enable)
//   locked [1:0]                    requester i is locked out
module secure_access_ctrl
    import secure_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int KEY_W       = DEF_KEY_W,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [1:0]          req_enc,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [2*KEY_W-1:0]  req_key,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_write,
    output logic                read_enable,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                encryption_on,
    input  logic [KEY_W-1:0]    mem_key,
    input  logic [DATA_W-1:0]   mem_read_data,
    output logic [1:0]          locked
);

    localparam int FAIL_W = $clog2(MAX_FAILS) + 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;

    state_t              state;
    logic                cur;
    logic                cur_we;
    logic                cur_enc;
    logic                cur_locked;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [KEY_W-1:0]    cur_key;
    logic [DATA_W-1:0]   rd_buf;
    logic                err_q;
    logic [FAIL_W-1:0]   fail_cnt [2];
    logic [LOCK_W-1:0]   lock_cnt [2];

    logic                gnt_valid;
    logic                gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [KEY_W-1:0]    sel_key;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .mask      (locked),
        .advance   (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_addr  = gnt_idx ? req_addr[2*ADDR_W-1 -: ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1 -: DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_key   = gnt_idx ? req_key[2*KEY_W-1 -: KEY_W]     : req_key[KEY_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cur            <= 1'b0;
            cur_we         <= 1'b0;
            cur_enc        <= 1'b0;
            cur_locked     <= 1'b0;
            cur_addr       <= '0;
            cur_wdata      <= '0;
            cur_key        <= '0;
            rd_buf         <= '0;
            err_q          <= 1'b0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            mem_address    <= '0;
            mem_write      <= 1'b0;
            read_enable    <= 1'b0;
            mem_write_data <= '0;
            encryption_on  <= 1'b0;
            locked         <= '0;
            for (int i = 0; i < 2; i++) begin
                fail_cnt[i] <= '0;
                lock_cnt[i] <= '0;
            end
        end else begin
            // Single-cycle pulses default low.
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            mem_write   <= 1'b0;
            read_enable <= 1'b0;

            // Lockout timers run regardless of the sequencer state.
            for (int i = 0; i < 2; i++) begin
                if (lock_cnt[i] != '0) begin
                    lock_cnt[i] <= lock_cnt[i] - LOCK_W'(1);
                    if (lock_cnt[i] == LOCK_W'(1)) begin
                        locked[i] <= 1'b0;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        req_ready[gnt_idx] <= 1'b1;
                        cur                <= gnt_idx;
                        cur_we             <= req_we[gnt_idx];
                        cur_enc            <= req_enc[gnt_idx];
                        cur_addr           <= sel_addr;
                        cur_wdata          <= sel_wdata;
                        cur_key            <= sel_key;
                        // Registered lock state: a lockout expiring on this
                        // same edge still counts as locked.
                        cur_locked         <= locked[gnt_idx];
                        state              <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (cur_locked) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end else if (cur_key == mem_key) begin
                        fail_cnt[cur]  <= '0;
                        err_q          <= 1'b0;
                        mem_address    <= cur_addr;
                        encryption_on  <= cur_enc;
                        mem_write_data <= cur_wdata;
                        mem_write      <= cur_we;
                        read_enable    <= ~cur_we;
                        state          <= ST_ACCESS;
                    end else begin
                        if (fail_cnt[cur] == FAIL_W'(MAX_FAILS - 1)) begin
                            locked[cur]   <= 1'b1;
                            lock_cnt[cur] <= LOCK_W'(LOCK_CYCLES);
                            fail_cnt[cur] <= '0;
                        end else begin
                            fail_cnt[cur] <= fail_cnt[cur] + FAIL_W'(1);
                        end
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end

                ST_ACCESS: begin
                    state <= cur_we ? ST_RESP : ST_WAIT;
                end

                ST_WAIT: begin
                    rd_buf <= mem_read_data;
                    state  <= ST_RESP;
                end

                ST_RESP: begin
                    rsp_valid[cur] <= 1'b1;
                    rsp_err        <= err_q;
                    rsp_data       <= (err_q || cur_we) ? '0 : rd_buf;
                    state          <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secure_access_ctrl.sv
// tb/tb_secure_access_ctrl.sv - self-checking bench for secure_access_ctrl
module tb_secure_access_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int KW = 16;
    localparam logic [KW-1:0] GOOD_KEY = 16'hA5A5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_we = '0;
    logic [1:0]        req_enc = '0;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic [2*KW-1:0]   req_key = '0;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     mem_address;
    logic              mem_write;
    logic              read_enable;
    logic [DW-1:0]     mem_write_data;
    logic              encryption_on;
    logic [KW-1:0]     mem_key = GOOD_KEY;
    logic [DW-1:0]     mem_read_data = '0;
    logic [1:0]        locked;

    secure_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .KEY_W(KW), .MAX_FAILS(3), .LOCK_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_enc(req_enc),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .mem_address(mem_address), .mem_write(mem_write), .read_enable(read_enable),
        .mem_write_data(mem_write_data), .encryption_on(encryption_on),
        .mem_key(mem_key), .mem_read_data(mem_read_data), .locked(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_hi = 0;
    int rd_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write)   wr_hi <= wr_hi + 1;
        if (read_enable) rd_hi <= rd_hi + 1;
    end

    typedef struct {
        int           idx;
        bit           we;
        bit           enc;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [KW-1:0] key;
        logic [DW-1:0] rdata;
        bit           exp_err;
        logic [DW-1:0] exp_data;
        int           exp_lat;
        int           exp_wr;
        int           exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " ctrl"}, {req_ready, rsp_valid, rsp_err, mem_write, read_enable,
                            encryption_on, locked}, 64'h0);
        chk({nm, " rsp_data"}, rsp_data, 64'h0);
        chk({nm, " mem_address"}, mem_address, 64'h0);
        chk({nm, " mem_write_data"}, mem_write_data, 64'h0);
    endtask

    // Issue one request, wait for grant and response, check everything.
    task automatic do_req(input vec_t v, input string nm);
        int  n;
        bit  got;
        int  wr0;
        int  rd0;
        wr0 = wr_hi;
        rd0 = rd_hi;
        mem_read_data = v.rdata;
        req_we[v.idx]  = v.we;
        req_enc[v.idx] = v.enc;
        req_addr[v.idx*AW +: AW]  = v.addr;
        req_wdata[v.idx*DW +: DW] = v.wdata;
        req_key[v.idx*KW +: KW]   = v.key;
        req_valid[v.idx] = 1'b1;
        got = 0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[v.idx]) got = 1;
        end
        req_valid[v.idx] = 1'b0;
        chk({nm, " grant"}, got, 1);
        if (got) begin
            n = 0;
            got = 0;
            while (!got && n < 100) begin
                @(negedge clk);
                n++;
                if (rsp_valid != 2'b00) got = 1;
            end
            chk({nm, " latency"}, n, v.exp_lat);
            chk({nm, " rsp_valid"}, rsp_valid, 2'b01 << v.idx);
            chk({nm, " rsp_err"}, rsp_err, v.exp_err);
            chk({nm, " rsp_data"}, rsp_data, v.exp_data);
            chk({nm, " wr_pulses"}, wr_hi - wr0, v.exp_wr);
            chk({nm, " rd_pulses"}, rd_hi - rd0, v.exp_rd);
            if (!v.exp_err) begin
                chk({nm, " mem_address"}, mem_address, v.addr);
                chk({nm, " encryption_on"}, encryption_on, v.enc);
                if (v.we) chk({nm, " mem_write_data"}, mem_write_data, v.wdata);
            end
        end
    endtask

    vec_t vt [11];
    vec_t v;
    int   g [8];
    int   ng;
    int   wr0;
    int   cyc_lock;
    int   seen;
    bit   got;

    initial begin
        //        idx we enc addr    wdata         key       rdata         err data          lat wr rd
        vt[0]  = '{0, 1, 0, 10'h003, 32'hDEADBEEF, GOOD_KEY, 32'h0,        0, 32'h0,        3, 1, 0};
        vt[1]  = '{0, 0, 1, 10'h003, 32'h0,        GOOD_KEY, 32'h12345678, 0, 32'h12345678, 4, 0, 1};
        vt[2]  = '{1, 1, 1, 10'h3FF, 32'h00000001, GOOD_KEY, 32'h0,        0, 32'h0,        3, 1, 0};
        vt[3]  = '{1, 0, 0, 10'h000, 32'h0,        GOOD_KEY, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 4, 0, 1};
        vt[4]  = '{0, 0, 0, 10'h011, 32'h0,        16'h0000, 32'h55555555, 1, 32'h0,        2, 0, 0};
        vt[5]  = '{0, 1, 0, 10'h012, 32'h77777777, 16'hA5A4, 32'h0,        1, 32'h0,        2, 0, 0};
        vt[6]  = '{0, 0, 0, 10'h005, 32'h0,        GOOD_KEY, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4, 0, 1};
        vt[7]  = '{0, 0, 1, 10'h006, 32'h0,        16'h0000, 32'h11111111, 1, 32'h0,        2, 0, 0};
        vt[8]  = '{0, 1, 0, 10'h007, 32'h22222222, 16'h5A5A, 32'h0,        1, 32'h0,        2, 0, 0};
        vt[9]  = '{0, 1, 1, 10'h2AA, 32'hA0A0A0A0, GOOD_KEY, 32'h0,        0, 32'h0,        3, 1, 0};
        vt[10] = '{1, 0, 1, 10'h155, 32'h0,        GOOD_KEY, 32'h0BADF00D, 0, 32'h0BADF00D, 4, 0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: writes, reads, key errors, fail-count clearing
        for (int i = 0; i < 11; i++) begin
            do_req(vt[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d locked", i), locked, 2'b00);
        end

        // Arbitration: both requesters continuously valid
        req_we    = 2'b11;
        req_enc   = 2'b00;
        req_addr  = {10'h020, 10'h010};
        req_wdata = {32'h0000BBBB, 32'h0000AAAA};
        req_key   = {GOOD_KEY, GOOD_KEY};
        wr0 = wr_hi;
        ng = 0;
        req_valid = 2'b11;
        for (int n = 0; n < 200 && ng < 8; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk($sformatf("arb onehot%0d", ng), $countones(req_ready), 1);
                g[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        req_valid = 2'b00;
        repeat (8) @(negedge clk);
        chk("arb grants", ng, 8);
        for (int k = 0; k < ng; k++) chk($sformatf("arb order%0d", k), g[k], k % 2);
        chk("arb writes", wr_hi - wr0, 8);

        // Lockout of requester 1
        v = '{1, 1, 0, 10'h040, 32'h12121212, 16'h0000, 32'h0, 1, 32'h0, 2, 0, 0};
        for (int k = 0; k < 3; k++) begin
            do_req(v, $sformatf("bad%0d", k));
            chk($sformatf("bad%0d locked", k), locked, (k == 2) ? 2'b10 : 2'b00);
        end
        cyc_lock = cyc;
        v = '{1, 1, 0, 10'h041, 32'h34343434, GOOD_KEY, 32'h0, 1, 32'h0, 2, 0, 0};
        do_req(v, "locked_req");
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (locked[1] == 1'b0) got = 1;
        end
        chk("unlock seen", got, 1);
        chk("lock duration", cyc - cyc_lock, 63);
        v = '{1, 1, 0, 10'h042, 32'h56565656, GOOD_KEY, 32'h0, 0, 32'h0, 3, 1, 0};
        do_req(v, "after_unlock");

        // Reset in the middle of a read (during WAIT)
        mem_read_data = 32'h99999999;
        req_we[0] = 1'b0;
        req_enc[0] = 1'b1;
        req_addr[AW-1:0] = 10'h077;
        req_key[KW-1:0] = GOOD_KEY;
        req_valid[0] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        req_valid[0] = 1'b0;
        chk("midrst grant", got, 1);
        @(negedge clk);
        chk("midrst read_enable", read_enable, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst async");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
        end
        chk("midrst no rsp", seen, 0);
        v = '{0, 0, 1, 10'h078, 32'h0, GOOD_KEY, 32'h31415926, 0, 32'h31415926, 4, 0, 1};
        do_req(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secure_access_ctrl.md
# secure_access_ctrl

Arbitrated, key-checked access sequencer in front of the `secure_system` memory/security datapath. Two requesters (0 = host, 1 = DMA) share one memory port. Each request has its key compared against the memory's `key_access` word before the access is issued. The block drives address, write strobe, read enable and `encryption_on`, and returns read data or an error. After repeated key failures the block locks out the offending requester for a fixed interval.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 32, data width
- KEY_W, 16, key width
- MAX_FAILS, 3, consecutive key failures per requester before lockout (1..15)
- LOCK_CYCLES, 64, lockout duration in clk cycles (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted (one-cycle pulse, at most one bit set)
- req_we  in  2  1 = write, 0 = read
- req_enc  in  2  request encrypted output
- req_addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  write data, same packing
- req_key  in  2*KEY_W  presented key, same packing
- rsp_valid  out  2  response pulse to requester i
- rsp_err  out  1  qualifies rsp_valid: 1 = key mismatch or locked
- rsp_data  out  DATA_W  read data; 0 on writes and errors
- mem_address  out  ADDR_W  to memory/registers address
- mem_write  out  1  memory write strobe
- read_enable  out  1  register-file read enable
- mem_write_data  out  DATA_W  write data
- encryption_on  out  1  to security stage
- mem_key  in  KEY_W  memory key_access word
- mem_read_data  in  DATA_W  secure_data_out, valid one cycle after read_enable
- locked  out  2  requester i in lockout

## Operation
FSM states: IDLE, CHECK, ACCESS, WAIT, RESP, all in one-hot or binary encoding.
- IDLE:
  - Pick among requesters with req_valid=1 and locked=0 using round-robin. Priority goes to the requester not granted last; after reset the last-granted value is 1, so requester 0 wins the first tie.
  - On a grant, pulse req_ready[i] and latch we, enc, addr, wdata and key. Go to CHECK.
- Locked requester:
  - A req_valid from a locked requester gets an immediate req_ready plus rsp_valid/rsp_err in RESP.
  - It goes through CHECK, but no memory access is issued.
- CHECK:
  - Compare the latched key with mem_key, sampled this cycle.
  - Match: clear fail_cnt[i]; go to ACCESS.
  - Mismatch: increment fail_cnt[i]. If it reaches MAX_FAILS, set locked[i], load lock_cnt[i]=LOCK_CYCLES and clear fail_cnt[i]. Go to RESP with err.
- ACCESS:
  - Drive mem_address and encryption_on from the latched values.
  - Write: mem_write=1 for exactly one cycle, then go to RESP.
  - Read: read_enable=1 for exactly one cycle, then go to WAIT.
- WAIT: capture mem_read_data into rsp_data; go to RESP.
- RESP: pulse rsp_valid[i] with rsp_err and rsp_data; go to IDLE.
- Lock counters:
  - Each lock_cnt decrements every cycle, independent of FSM state.
  - At 1→0, locked[i] clears in the same cycle.
- Simultaneous events:
  - If a lockout expires in the same cycle as an IDLE arbitration, the request is treated as locked.
  - Fail-counter increment and clear never coincide, since only one requester is served at a time.
- req_valid deasserted after req_ready has no effect: the request is already latched.
- Reset mid-operation: all state returns to reset values immediately. An in-flight access is abandoned with no rsp_valid.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_address=0, mem_write=0, read_enable=0, mem_write_data=0, encryption_on=0, locked=0. FSM state is IDLE; fail and lock counters are 0.
- All outputs are registered.
- Latency from req_ready to rsp_valid:
  - Read: 4 cycles.
  - Write: 3 cycles.
  - Key error: 2 cycles.
- Back-to-back requests: a new grant is possible the cycle after RESP, giving a throughput of 1 read per 5 cycles.
- mem_address and encryption_on hold their value from ACCESS through RESP.

## Structure
- Package secure_pkg holds the FSM state enum and the default width constants (ADDR_W/DATA_W/KEY_W), shared with secure_system.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with mask input (locked) and last-grant register.
- Per-requester fail/lock counters are inline; their widths are $clog2 of the respective parameter, +1.

## Test plan
- **Reset and write:** reset, mem_key=16'hA5A5, requester 0 writes addr 10'h3 data 32'hDEADBEEF with key A5A5 → mem_write pulses once with mem_address=3; rsp_valid[0] after 3 cycles with err=0.
- **Read:** read addr 3 with enc=1, mem_read_data=32'h1234_5678 → read_enable one cycle, encryption_on=1; rsp_data=32'h12345678 after 4 cycles.
- **Arbitration:** both requesters valid continuously → grants alternate 0,1,0,1; no starvation over 8 requests.
- **Lockout:** 3 bad keys (16'h0000) from requester 1 → three err responses, no mem_write/read_enable, and locked[1]=1. A request during lockout gets an err response. locked[1] clears after 64 cycles, and a good key then succeeds.
- **Reset mid-operation:** assert rst_n=0 during WAIT → outputs return to reset values asynchronously, no rsp_valid; the first request after reset is served normally.
- **Fail-count clear:** 2 bad keys then 1 good key from requester 0, then 2 more bad keys → no lockout (fail_cnt cleared by the success).
